// File: rtl/fht_pkg.sv
// Shared definitions for the FHT address/control generator.
//   fht_state_e   : sequencer states (idle, read sweep, pipeline drain)
//   L_MIN         : smallest supported log2 transform length
//   l_max()       : largest supported log2 length for a given bank address width
//   clamp_log_len : limits a requested log2 length to [L_MIN, l_max(a_bit)]
//   bitrev        : reverses the low 'width' bits of a value, upper bits zero
package fht_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StDrain
  } fht_state_e;

  localparam int L_MIN = 3;

  // Four banks of 2^a_bit words hold at most 2^(a_bit+2) points.
  function automatic int l_max(input int a_bit);
    return a_bit + 2;
  endfunction

  function automatic int clamp_log_len(input int log_len, input int a_bit);
    if (log_len < L_MIN) return L_MIN;
    if (log_len > l_max(a_bit)) return l_max(a_bit);
    return log_len;
  endfunction

  function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
    logic [31:0] r;
    logic [4:0]  dst;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) begin
        dst    = 5'(width - 1 - i);
        r[dst] = value[5'(i)];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fht_control_gen_if.sv
// Control/address bundle between the FHT sequencer and its user/datapath.
//   master : drives iSTART/iLOG_LEN (and iSTALL when built with FHT_STALL_EN)
//   slave  : the sequencer; drives stage flags, bank addresses, write enables, oRDY
// Optional feature macro: FHT_STALL_EN adds iSTALL.
interface fht_control_gen_if #(
  parameter int unsigned A_BIT = 8,
  parameter int unsigned L_BIT = 4
);
  logic             iSTART;
  logic [L_BIT-1:0] iLOG_LEN;
`ifdef FHT_STALL_EN
  logic             iSTALL;
`endif
  logic [L_BIT-1:0] oSTAGE;
  logic             oST_ZERO;
  logic             oST_LAST;
  logic [A_BIT-1:0] oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3;
  logic [A_BIT-1:0] oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3;
  logic [A_BIT-1:0] oADDR_COEF;
  logic             oWE_A;
  logic             oWE_B;
  logic             oSOURCE;
  logic             oRDY;

  modport master (
`ifdef FHT_STALL_EN
    output iSTALL,
`endif
    output iSTART, iLOG_LEN,
    input  oSTAGE, oST_ZERO, oST_LAST,
    input  oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3,
    input  oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3,
    input  oADDR_COEF, oWE_A, oWE_B, oSOURCE, oRDY
  );

  modport slave (
`ifdef FHT_STALL_EN
    input  iSTALL,
`endif
    input  iSTART, iLOG_LEN,
    output oSTAGE, oST_ZERO, oST_LAST,
    output oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3,
    output oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3,
    output oADDR_COEF, oWE_A, oWE_B, oSOURCE, oRDY
  );
endinterface

// File: rtl/fht_delay_line.sv
// Fixed-depth register shift line with a common advance enable.
//   clk_i, rst_ni : clock, asynchronous active-low reset (all stages clear to 0)
//   en_i          : shift when high, hold every stage when low
//   d_i / q_o     : data in / data out Depth cycles (enabled edges) later
module fht_delay_line #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);
  logic [Depth-1:0][Width-1:0] stage_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_q <= '0;
    end else if (en_i) begin
      stage_q[0] <= d_i;
      for (int i = 1; i < int'(Depth); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[Depth-1];
endmodule

// File: rtl/fht_control_gen.sv
// Runtime-length FHT stage sequencer. For an N = 2^L point transform spread over four
// banks it sweeps L-1 stages of 2^(L-2) butterflies, producing four registered read
// addresses and a coefficient address per cycle, then replays the read addresses as
// write addresses PIPE_LAT cycles later with ping-pong write enables.
//   iCLK, iRESET : clock, asynchronous active-low reset
//   bus (slave)  : iSTART/iLOG_LEN in; oSTAGE, oST_ZERO, oST_LAST, oADDR_RD_0..3,
//                  oADDR_WR_0..3, oADDR_COEF, oWE_A, oWE_B, oSOURCE, oRDY out
// Optional feature macro: FHT_STALL_EN adds bus.iSTALL, which freezes the sweep, the
// drain counter and the write pipeline and masks both write enables.
module fht_control_gen
  import fht_pkg::*;
#(
  parameter int unsigned A_BIT    = 8,
  parameter int unsigned PIPE_LAT = 4,
  parameter int unsigned L_BIT    = 4
) (
  input logic              iCLK,
  input logic              iRESET,
  fht_control_gen_if.slave bus
);
  localparam int unsigned DcntW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam int unsigned LineW = 2 + 4 * A_BIT;

  fht_state_e                  state_q, state_d;
  logic [A_BIT-1:0]            t_q, t_d;
  logic [L_BIT-1:0]            s_q, s_d;
  logic [L_BIT-1:0]            len_q, len_d;
  logic [DcntW-1:0]            dcnt_q, dcnt_d;
  logic [3:0][A_BIT-1:0]       rd_q, rd_d;
  logic [A_BIT-1:0]            coef_q, coef_d;
  logic                        rd_valid_q, rd_valid_d;
  logic                        rd_par_q, rd_par_d;
  logic                        stall, busy, t_last, s_last, d_last;
  logic [LineW-1:0]            line_in, line_out;
  logic                        wr_valid, wr_par;
  logic [3:0][A_BIT-1:0]       wr_addr;

  // Banks 0/1 read t, banks 2/3 read the butterfly partner t ^ 2^(s-1); stage 0 reads
  // in bit-reversed order on all banks.
  function automatic logic [A_BIT-1:0] rd_addr(input logic [L_BIT-1:0] len,
                                               input logic [L_BIT-1:0] s,
                                               input logic [A_BIT-1:0] t,
                                               input logic             hi);
    if (s == '0) return A_BIT'(bitrev(32'(t), int'(len) - 2));
    return A_BIT'(32'(t) ^ (hi ? (32'd1 << (32'(s) - 32'd1)) : 32'd0));
  endfunction

  // Twiddle index (t mod 2^s) scaled to the full ROM range.
  function automatic logic [A_BIT-1:0] coef_addr(input logic [L_BIT-1:0] s,
                                                 input logic [A_BIT-1:0] t);
    logic [31:0] mask;
    if (s == '0) return '0;
    mask = (32'd1 << 32'(s)) - 32'd1;
    return A_BIT'((32'(t) & mask) << (32'(A_BIT) - 32'(s)));
  endfunction

`ifdef FHT_STALL_EN
  assign stall = bus.iSTALL && (state_q != StIdle);
`else
  assign stall = 1'b0;
`endif

  assign busy   = (state_q != StIdle);
  assign t_last = (t_q == A_BIT'((32'd1 << (32'(len_q) - 32'd2)) - 32'd1));
  assign s_last = (s_q == len_q - L_BIT'(2));
  assign d_last = (dcnt_q == DcntW'(PIPE_LAT - 1));

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    s_d     = s_q;
    len_d   = len_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      StIdle: begin
        if (bus.iSTART) begin
          len_d   = L_BIT'(clamp_log_len(int'(bus.iLOG_LEN), int'(A_BIT)));
          s_d     = '0;
          t_d     = '0;
          state_d = StRead;
        end
      end
      StRead: begin
        if (t_last) begin
          dcnt_d  = '0;
          state_d = StDrain;
        end else begin
          t_d = t_q + A_BIT'(1);
        end
      end
      StDrain: begin
        if (d_last) begin
          if (s_last) begin
            s_d     = '0;
            state_d = StIdle;
          end else begin
            s_d     = s_q + L_BIT'(1);
            t_d     = '0;
            state_d = StRead;
          end
        end else begin
          dcnt_d = dcnt_q + DcntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    if (stall) begin
      state_d = state_q;
      t_d     = t_q;
      s_d     = s_q;
      len_d   = len_q;
      dcnt_d  = dcnt_q;
    end
  end

  // Addresses are computed from next-state values so the registered outputs line up
  // with the READ cycle they belong to; outside READ they hold.
  always_comb begin
    rd_d       = rd_q;
    coef_d     = coef_q;
    rd_valid_d = (state_d == StRead);
    rd_par_d   = s_d[0];
    if (state_d == StRead) begin
      rd_d[0] = rd_addr(len_d, s_d, t_d, 1'b0);
      rd_d[1] = rd_addr(len_d, s_d, t_d, 1'b0);
      rd_d[2] = rd_addr(len_d, s_d, t_d, 1'b1);
      rd_d[3] = rd_addr(len_d, s_d, t_d, 1'b1);
      coef_d  = coef_addr(s_d, t_d);
    end
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_q    <= StIdle;
      t_q        <= '0;
      s_q        <= '0;
      len_q      <= L_BIT'(L_MIN);
      dcnt_q     <= '0;
      rd_q       <= '0;
      coef_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      s_q     <= s_d;
      len_q   <= len_d;
      dcnt_q  <= dcnt_d;
      if (!stall) begin
        rd_q       <= rd_d;
        coef_q     <= coef_d;
        rd_valid_q <= rd_valid_d;
        rd_par_q   <= rd_par_d;
      end
    end
  end

  // Read addresses hold outside READ and the drain is PIPE_LAT long, so the line
  // output already holds the last write address between write bursts.
  assign line_in = {rd_valid_q, rd_par_q, rd_q};

  fht_delay_line #(
    .Width (LineW),
    .Depth (PIPE_LAT)
  ) u_wr_line (
    .clk_i  (iCLK),
    .rst_ni (iRESET),
    .en_i   (!stall),
    .d_i    (line_in),
    .q_o    (line_out)
  );

  assign {wr_valid, wr_par, wr_addr} = line_out;

  assign bus.oRDY       = !busy;
  assign bus.oSTAGE     = s_q;
  assign bus.oST_ZERO   = busy && (s_q == '0);
  assign bus.oST_LAST   = busy && s_last;
  assign bus.oSOURCE    = s_q[0];
  assign bus.oADDR_RD_0 = rd_q[0];
  assign bus.oADDR_RD_1 = rd_q[1];
  assign bus.oADDR_RD_2 = rd_q[2];
  assign bus.oADDR_RD_3 = rd_q[3];
  assign bus.oADDR_COEF = coef_q;
  assign bus.oADDR_WR_0 = wr_addr[0];
  assign bus.oADDR_WR_1 = wr_addr[1];
  assign bus.oADDR_WR_2 = wr_addr[2];
  assign bus.oADDR_WR_3 = wr_addr[3];
  // Even stages read set A and write set B; odd stages the reverse.
  assign bus.oWE_B      = wr_valid && !wr_par && !stall;
  assign bus.oWE_A      = wr_valid && wr_par && !stall;
endmodule

// File: doc/fht_control_gen.md
Name: fht_control_gen

Overview:
Runtime-length successor to the fixed-length FHT controller. It sequences every stage of an N = 2^L point Hartley transform held in four data banks, each of depth 2^A_BIT. Per cycle it generates four read addresses, four write addresses and a coefficient address. It drives ping-pong write enables and stage flags to the butterfly datapath, and supports a runtime-selected length and a configurable butterfly pipeline latency.

Parameters:
A_BIT, 8, bank address width; maximum L = A_BIT+2
PIPE_LAT, 4, read-to-write latency of the butterfly datapath in cycles (>=1)
L_BIT, 4, width of iLOG_LEN

Ports:
iCLK  in  1  clock
iRESET  in  1  asynchronous active-low reset
iSTART  in  1  start pulse, sampled only while oRDY=1
iLOG_LEN  in  L_BIT  log2 of transform length, latched on accepted start
oSTAGE  out  L_BIT  current stage index s
oST_ZERO  out  1  high while s==0
oST_LAST  out  1  high while s==NS-1
oADDR_RD_0..3  out  A_BIT each  bank read addresses
oADDR_WR_0..3  out  A_BIT each  bank write addresses
oADDR_COEF  out  A_BIT  coefficient ROM address
oWE_A  out  1  write enable, bank set A
oWE_B  out  1  write enable, bank set B
oSOURCE  out  1  bank set being read: 0=A, 1=B
oRDY  out  1  idle/done

Behaviour:
- Reset (async, iRESET=0): state IDLE; all addresses, oSTAGE and WE outputs 0; oSOURCE=0; oRDY=1. Asserting reset mid-transform aborts immediately, with no completion pulse.
- Length handling:
  - L = iLOG_LEN clamped to [3, A_BIT+2].
  - M = 2^(L-2) butterflies per stage; NS = L-1 stages; s = 0..NS-1.
- States: IDLE -> READ -> DRAIN -> (READ for s+1 | IDLE).
  - IDLE: oRDY=1. iSTART=1 at an edge latches L, sets s=0, t=0, and moves to READ. oRDY falls the same edge.
  - READ: t counts 0..M-1, one per cycle. At t==M-1 go to DRAIN.
  - DRAIN: exactly PIPE_LAT cycles. Then, if s<NS-1, s++, t=0, back to READ; otherwise IDLE, and oRDY rises.
- iSTART outside IDLE is ignored.
- Cycle count: busy for exactly NS*(M+PIPE_LAT) cycles from the start edge.
- Read addresses are registered and valid in READ cycles:
  - s==0: all four banks = bitrev over (L-2) bits of t.
  - s>=1: ADDR_RD_k = t XOR (k[1] ? 2^(s-1) : 0).
  - Upper bits above L-2 are always 0.
- oADDR_COEF in READ: (t mod 2^s) << (A_BIT-s), truncated to A_BIT bits; 0 when s==0.
- Write side:
  - oADDR_WR_k is ADDR_RD_k delayed PIPE_LAT cycles through a shift register.
  - The write strobe is the READ-valid flag delayed identically.
  - oWE_B = strobe & (s even); oWE_A = strobe & (s odd). s is the stage that issued the read; it is carried in the pipeline.
- oSOURCE = s[0] for the stage being read. It holds through DRAIN.
- oST_ZERO and oST_LAST follow oSTAGE. They are 0 in IDLE.
- Outside READ, read addresses hold their last value. Outside a write strobe, write addresses hold.

Optional Feature:
FHT_STALL_EN
- Defined: adds input iSTALL (1 bit). While iSTALL=1, the t counter, the DRAIN counter, the state and the write pipeline all freeze, and WE outputs are forced 0. Everything resumes unchanged when iSTALL falls, so no address is skipped or repeated. iSTALL has no effect in IDLE.
- Undefined: the port is absent and the block runs uninterrupted.

Decomposition:
- Shared package fht_pkg holds:
  - the state enum (IDLE, READ, DRAIN)
  - constants L_MIN=3 and L_MAX=A_BIT+2
  - a bitrev function
  - the clamp function for iLOG_LEN
- One sub-module: fht_delay_line, a PIPE_LAT-deep register shift line carrying {valid, stage parity, 4 addresses}. It is reused later for datapath alignment.

Test Plan:
- Config A_BIT=4, PIPE_LAT=2, iLOG_LEN=4, start pulse -> oRDY low 18 cycles. Stage 0 reads 0,2,1,3 on all banks. Stage 1 bank2/3 read 1,0,3,2 while bank0/1 read 0,1,2,3. oWE_B only in stage 0 and 2 writes, oWE_A only in stage 1.
- Same config: check write timing -> oADDR_WR equals oADDR_RD exactly 2 cycles later. No WE in the 2 cycles after start. WE count per stage = 4.
- iLOG_LEN=2 and iLOG_LEN=15 -> clamped to L=3 (busy 2*(2+2)=8 cycles) and L=6 (busy 5*(16+2)=90 cycles) respectively.
- iSTART pulsed during stage 1, then reset pulled low at cycle 10 -> the start pulse is ignored. On reset all outputs are 0 and oRDY=1 asynchronously. A new start then runs a full 18-cycle transform.
- Coefficient check, L=6, s=3, A_BIT=4 -> oADDR_COEF sequence 0,2,4,...,14 repeating every 8 t.
- FHT_STALL_EN: iSTALL high 3 cycles mid stage 1 at t=2 -> addresses frozen, WE=0. Total busy 18+3 cycles. Write sequence identical to the unstalled run.
